mem_arbiter: RTL

- Arbitrates the single byte-serial memory-controller request port between three requesters: instruction fetch (IF), load (LD) and store (ST).
- Sits between the fetch unit / load-store buffer and the memory controller.
- Holds one transaction in flight and routes the completion back to its owner.
- Adds fixed priority with anti-starvation for fetch, a fetch flush that drops a stale result, and back-pressure for stores to IO space.

---
 rtl/mem_arbiter.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Summary  : Fetch/load/store arbiter for one byte-serial memory controller
//            port; one transaction in flight, completion routed to its owner.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int         STARVE_LIMIT = 4,
  parameter logic [1:0] IO_BASE_HI   = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_buffer_full,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [1:0]  ld_size,
  output logic        ld_done,
  output logic [31:0] ld_data,
  input  logic        st_req,
  input  logic [31:0] st_addr,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_data,
  output logic        st_done,
  output logic        mc_req,
  output logic        mc_we,
  output logic [31:0] mc_addr,
  output logic [1:0]  mc_size,
  output logic [31:0] mc_wdata,
  input  logic        mc_done,
  input  logic [31:0] mc_rdata
);

  localparam int                 c_CNT_W     = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_CNT_W-1:0] c_LIMIT     = c_CNT_W'(STARVE_LIMIT);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
  localparam logic [1:0]         c_SIZE_WORD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_IF = 2'd0,
    OWN_LD = 2'd1,
    OWN_ST = 2'd2
  } owner_t;

  state_t             r_state;
  state_t             w_state_nxt;
  owner_t             r_owner;
  owner_t             w_grant_owner;
  logic [c_CNT_W-1:0] r_starve_cnt;
  logic [2:0]         r_last_done;

  logic               r_mc_req;
  logic               r_mc_we;
  logic [31:0]        r_mc_addr;
  logic [1:0]         r_mc_size;
  logic [31:0]        r_mc_wdata;
  logic               r_if_done;
  logic               r_ld_done;
  logic               r_st_done;
  logic [31:0]        r_if_data;
  logic [31:0]        r_ld_data;

  logic               w_if_elig;
  logic               w_ld_elig;
  logic               w_st_elig;
  logic               w_st_io_blocked;
  logic               w_grant;
  logic               w_complete;
  logic               w_if_flushed;

  // Eligibility and arbitration; only meaningful in IDLE.
  always_comb begin
    w_st_io_blocked = (st_addr[17:16] == IO_BASE_HI) && io_buffer_full;
    w_if_elig       = if_req && !flush && !r_last_done[0];
    w_ld_elig       = ld_req && !r_last_done[1];
    w_st_elig       = st_req && !r_last_done[2] && !w_st_io_blocked;
    w_grant         = 1'b0;
    w_grant_owner   = OWN_IF;
    if (r_state == S_IDLE) begin
      if (w_if_elig && (r_starve_cnt == c_LIMIT)) begin
        w_grant       = 1'b1;
        w_grant_owner = OWN_IF;
      end else if (w_ld_elig) begin
        w_grant       = 1'b1;
        w_grant_owner = OWN_LD;
      end else if (w_st_elig) begin
        w_grant       = 1'b1;
        w_grant_owner = OWN_ST;
      end else if (w_if_elig) begin
        w_grant       = 1'b1;
        w_grant_owner = OWN_IF;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A flush landing on the completion cycle of a fetch still discards it.
  always_comb begin
    w_state_nxt  = r_state;
    w_complete   = 1'b0;
    w_if_flushed = (r_owner == OWN_IF) && flush;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (mc_done) begin
          w_state_nxt = S_IDLE;
          w_complete  = !w_if_flushed;
        end else if (w_if_flushed) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (mc_done) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner      <= OWN_IF;
      r_starve_cnt <= '0;
      r_last_done  <= '0;
      r_mc_req     <= 1'b0;
      r_mc_we      <= 1'b0;
      r_mc_addr    <= '0;
      r_mc_size    <= '0;
      r_mc_wdata   <= '0;
      r_if_done    <= 1'b0;
      r_ld_done    <= 1'b0;
      r_st_done    <= 1'b0;
      r_if_data    <= '0;
      r_ld_data    <= '0;
    end else begin
      r_if_done   <= w_complete && (r_owner == OWN_IF);
      r_ld_done   <= w_complete && (r_owner == OWN_LD);
      r_st_done   <= w_complete && (r_owner == OWN_ST);
      r_last_done <= {w_complete && (r_owner == OWN_ST),
                      w_complete && (r_owner == OWN_LD),
                      w_complete && (r_owner == OWN_IF)};

      if (w_complete && (r_owner == OWN_IF)) begin
        r_if_data <= mc_rdata;
      end
      if (w_complete && (r_owner == OWN_LD)) begin
        r_ld_data <= mc_rdata;
      end

      // Request fields are captured once per grant and held until mc_done.
      if (w_grant) begin
        r_owner  <= w_grant_owner;
        r_mc_req <= 1'b1;
        case (w_grant_owner)
          OWN_LD: begin
            r_mc_addr  <= ld_addr;
            r_mc_size  <= ld_size;
            r_mc_we    <= 1'b0;
            r_mc_wdata <= '0;
          end
          OWN_ST: begin
            r_mc_addr  <= st_addr;
            r_mc_size  <= st_size;
            r_mc_we    <= 1'b1;
            r_mc_wdata <= st_data;
          end
          default: begin
            r_mc_addr  <= if_addr;
            r_mc_size  <= c_SIZE_WORD;
            r_mc_we    <= 1'b0;
            r_mc_wdata <= '0;
          end
        endcase
      end else if (mc_done && (r_state != S_IDLE)) begin
        r_mc_req <= 1'b0;
      end

      if (!if_req) begin
        r_starve_cnt <= '0;
      end else if (w_grant) begin
        if (w_grant_owner == OWN_IF) begin
          r_starve_cnt <= '0;
        end else if (r_starve_cnt != c_LIMIT) begin
          r_starve_cnt <= r_starve_cnt + c_CNT_ONE;
        end
      end
    end
  end

  assign mc_req   = r_mc_req;
  assign mc_we    = r_mc_we;
  assign mc_addr  = r_mc_addr;
  assign mc_size  = r_mc_size;
  assign mc_wdata = r_mc_wdata;
  assign if_done  = r_if_done;
  assign ld_done  = r_ld_done;
  assign st_done  = r_st_done;
  assign if_data  = r_if_data;
  assign ld_data  = r_ld_data;

endmodule
`default_nettype wire
